// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ctrl bit positions, named ALU ops, FSM states.
package alu_arbiter_pkg;

  localparam int XLEN   = 16;
  localparam int CTRL_W = 6;

  // ctrl = {zx, nx, zy, ny, f, no}
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  localparam logic [CTRL_W-1:0] ALU_X_PLUS_Y  = 6'b000010;
  localparam logic [CTRL_W-1:0] ALU_X_MINUS_Y = 6'b010011;
  localparam logic [CTRL_W-1:0] ALU_X_AND_Y   = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Rotate-priority one-hot picker: first valid requester after last_grant, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_valid
);

  logic found;
  int   pos;

  assign any_valid = |valid;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    pos      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last_grant) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && valid[j] && (j == pos)) begin
          grant[j] = 1'b1;
          grant_id = ID_W'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Combinational Hack ALU: optional zero/negate of each operand, add or and, optional negate of result.
module arithmetic_logic_unit
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0]   x,
  input  logic [XLEN-1:0]   y,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   out,
  output logic              zr,
  output logic              ng
);

  logic [XLEN-1:0] x_z;
  logic [XLEN-1:0] x_n;
  logic [XLEN-1:0] y_z;
  logic [XLEN-1:0] y_n;
  logic [XLEN-1:0] f_out;

  assign x_z   = ctrl[CTRL_ZX] ? '0 : x;
  assign x_n   = ctrl[CTRL_NX] ? ~x_z : x_z;
  assign y_z   = ctrl[CTRL_ZY] ? '0 : y;
  assign y_n   = ctrl[CTRL_NY] ? ~y_z : y_z;
  // The add wraps; carry-out is intentionally dropped.
  assign f_out = ctrl[CTRL_F] ? (x_n + y_n) : (x_n & y_n);
  assign out   = ctrl[CTRL_NO] ? ~f_out : f_out;
  assign zr    = (out == '0);
  assign ng    = out[XLEN-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Hack ALU among NUM_REQ requesters, one op in flight.
// Optional keep-grant behaviour enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_x,
  input  logic [16*NUM_REQ-1:0]   req_y,
  input  logic [6*NUM_REQ-1:0]    req_ctrl,
  input  logic [NUM_REQ-1:0]      req_lock,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic                    rsp_zr,
  output logic                    rsp_ng,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  state_t              state_reg;
  state_t              state_next;
  logic [XLEN-1:0]     x_reg;
  logic [XLEN-1:0]     y_reg;
  logic [CTRL_W-1:0]   ctrl_reg;
  logic [ID_W-1:0]     id_reg;
  logic [XLEN-1:0]     rsp_data_reg;
  logic                rsp_zr_reg;
  logic                rsp_ng_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  logic [ID_W-1:0]     last_grant_reg;

  logic [XLEN-1:0]     x_lane    [NUM_REQ];
  logic [XLEN-1:0]     y_lane    [NUM_REQ];
  logic [CTRL_W-1:0]   ctrl_lane [NUM_REQ];

  logic [NUM_REQ-1:0]  rr_grant;
  logic [ID_W-1:0]     rr_id;
  logic                rr_any;
  logic [NUM_REQ-1:0]  grant_sel;
  logic [ID_W-1:0]     grant_id_sel;
  logic                accept;

  logic [XLEN-1:0]     sel_x;
  logic [XLEN-1:0]     sel_y;
  logic [CTRL_W-1:0]   sel_ctrl;
  logic [XLEN-1:0]     alu_out;
  logic                alu_zr;
  logic                alu_ng;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign x_lane[gi]    = req_x[16*gi +: 16];
    assign y_lane[gi]    = req_y[16*gi +: 16];
    assign ctrl_lane[gi] = req_ctrl[6*gi +: 6];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .valid      (req_valid),
    .last_grant (last_grant_reg),
    .grant      (rr_grant),
    .grant_id   (rr_id),
    .any_valid  (rr_any)
  );

`ifdef ALU_ARB_LOCK_EN
  logic               lock_flag_reg;
  logic [NUM_REQ-1:0] lock_onehot;
  logic               lock_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lock
    assign lock_onehot[gi] = (last_grant_reg == ID_W'(gi));
  end

  // A locked previous winner that is still asking overrides the rotation.
  assign lock_hit     = lock_flag_reg && |(lock_onehot & req_valid);
  assign grant_sel    = lock_hit ? lock_onehot : rr_grant;
  assign grant_id_sel = lock_hit ? last_grant_reg : rr_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_flag_reg <= 1'b0;
    end else if (accept) begin
      lock_flag_reg <= |(req_lock & grant_sel);
    end
  end
`else
  logic unused_lock;
  assign unused_lock  = ^req_lock;
  assign grant_sel    = rr_grant;
  assign grant_id_sel = rr_id;
`endif

  // Ready is gated by reset so the accept strobe reads 0 while rst_n is low.
  assign accept    = (state_reg == ST_IDLE) && rst_n && rr_any;
  assign req_ready = accept ? grant_sel : '0;

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_ctrl = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_sel[j]) begin
        sel_x    = x_lane[j];
        sel_y    = y_lane[j];
        sel_ctrl = ctrl_lane[j];
      end
    end
  end

  arithmetic_logic_unit u_alu (
    .x    (x_reg),
    .y    (y_reg),
    .ctrl (ctrl_reg),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      ctrl_reg       <= '0;
      id_reg         <= '0;
      rsp_data_reg   <= '0;
      rsp_zr_reg     <= 1'b0;
      rsp_ng_reg     <= 1'b0;
      rsp_id_reg     <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg    <= sel_x;
        y_reg    <= sel_y;
        ctrl_reg <= sel_ctrl;
        id_reg   <= grant_id_sel;
      end
      if (state_reg == ST_EXEC) begin
        rsp_data_reg <= alu_out;
        rsp_zr_reg   <= alu_zr;
        rsp_ng_reg   <= alu_ng;
        rsp_id_reg   <= id_reg;
      end
      // Rotation advances only once the consumer has taken the result.
      if ((state_reg == ST_RESP) && rsp_ready) begin
        last_grant_reg <= rsp_id_reg;
      end
    end
  end

  assign rsp_valid = (state_reg == ST_RESP);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_data  = rsp_data_reg;
  assign rsp_zr    = rsp_zr_reg;
  assign rsp_ng    = rsp_ng_reg;
  assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model plus directed and random stimulus.
module tb_alu_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [16*N-1:0]  req_x;
  logic [16*N-1:0]  req_y;
  logic [6*N-1:0]   req_ctrl;
  logic [N-1:0]     req_lock;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic             rsp_zr;
  logic             rsp_ng;
  logic [1:0]       rsp_id;
  logic             busy;

  logic [N-1:0]     drv_valid;
  logic [N-1:0]     drv_lock;
  logic [15:0]      drv_x    [N];
  logic [15:0]      drv_y    [N];
  logic [5:0]       drv_ctrl [N];

  always #5 clk = ~clk;

  always_comb begin
    req_x    = '0;
    req_y    = '0;
    req_ctrl = '0;
    for (int i = 0; i < N; i++) begin
      req_x[16*i +: 16]  = drv_x[i];
      req_y[16*i +: 16]  = drv_y[i];
      req_ctrl[6*i +: 6] = drv_ctrl[i];
    end
  end
  assign req_valid = drv_valid;
  assign req_lock  = drv_lock;

  alu_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ctrl  (req_ctrl),
    .req_lock  (req_lock),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zr    (rsp_zr),
    .rsp_ng    (rsp_ng),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hack ALU semantics: optional zero/negate per operand, add or and, optional negate.
  function automatic logic [17:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    a = c[5] ? 16'h0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? 16'(a + b) : (a & b);
    if (c[0]) o = ~o;
    return {(o == 16'h0), o[15], o};
  endfunction

  // Transaction-level model state
  bit           m_inflight  = 0;
  int           m_acc       = 0;
  logic [15:0]  m_data      = '0;
  logic         m_zr        = 0;
  logic         m_ng        = 0;
  int           m_id        = 0;
  int           m_last      = N - 1;
  bit           m_lock      = 0;
  bit           m_after_rst = 0;

  logic [N-1:0] ready_seen = '0;
  int           grant_log[$];
  int           rsp_id_log[$];
  logic [17:0]  rsp_res_log[$];
  int           last_acc_cyc  = 0;
  int           last_rise_cyc = 0;
  logic         prev_valid    = 0;

  function automatic int model_winner(input logic [N-1:0] v);
`ifdef ALU_ARB_LOCK_EN
    if (m_lock && v[m_last]) return m_last;
`endif
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // Compare process: checks every cycle at the falling edge, then advances the model.
  initial begin : compare
    int           w;
    logic [N-1:0] exp_ready;
    bit           exp_valid;
    logic [17:0]  r;
    forever begin
      @(negedge clk);
      if (m_after_rst) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zr", rsp_zr, 0);
        chk("rst_rsp_ng", rsp_ng, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
      end
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 0);
        m_inflight  = 0;
        m_last      = N - 1;
        m_lock      = 0;
        m_after_rst = 1;
        ready_seen  = '0;
        prev_valid  = 0;
      end else begin
        m_after_rst = 0;
        exp_valid = m_inflight && (cyc >= m_acc + 2);
        w = m_inflight ? -1 : model_winner(req_valid);
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_inflight);
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
          chk("rsp_data", rsp_data, m_data);
          chk("rsp_zr", rsp_zr, m_zr);
          chk("rsp_ng", rsp_ng, m_ng);
          chk("rsp_id", rsp_id, m_id);
        end
        if (rsp_valid && !prev_valid) last_rise_cyc = cyc;
        prev_valid = rsp_valid;
        if (exp_valid && rsp_ready) begin
          $display("rsp id=%0d data=%h zr=%0d ng=%0d cycle=%0d", rsp_id, rsp_data, rsp_zr, rsp_ng, cyc);
          rsp_id_log.push_back(int'(rsp_id));
          rsp_res_log.push_back({rsp_zr, rsp_ng, rsp_data});
          m_inflight = 0;
          m_last     = m_id;
        end
        if (w >= 0) begin
          r            = ref_alu(drv_x[w], drv_y[w], drv_ctrl[w]);
          m_inflight   = 1;
          m_acc        = cyc;
          m_data       = r[15:0];
          m_ng         = r[16];
          m_zr         = r[17];
          m_id         = w;
          m_lock       = drv_lock[w];
          last_acc_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) grant_log.push_back(i);
        end
        ready_seen = req_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ready_seen[i]) drv_valid[i] = 1'b0;
    end
  endtask

  task automatic issue(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic [5:0] c, input logic lk);
    drv_x[i]     = x;
    drv_y[i]     = y;
    drv_ctrl[i]  = c;
    drv_lock[i]  = lk;
    drv_valid[i] = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    drv_valid = '0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int t = 0;
    while (((drv_valid != 0) || busy) && (t < budget)) begin
      tick();
      t++;
    end
    chk("quiet_timeout", (t < budget), 1);
  endtask

  task automatic run_one(input string name, input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c, input logic [15:0] ed, input logic ez, input logic en);
    logic [17:0] res;
    rsp_res_log.delete();
    rsp_id_log.delete();
    issue(i, x, y, c, 1'b0);
    wait_quiet(30);
    chk({name, "_count"}, rsp_res_log.size(), 1);
    if (rsp_res_log.size() > 0) begin
      res = rsp_res_log[0];
      chk({name, "_data"}, res[15:0], ed);
      chk({name, "_zr"}, res[17], ez);
      chk({name, "_ng"}, res[16], en);
      chk({name, "_id"}, rsp_id_log[0], i);
    end
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin : stim
    int t;
    int exp3[6];
    int exp6[3];
    exp3 = '{0, 1, 2, 3, 0, 1};
`ifdef ALU_ARB_LOCK_EN
    exp6 = '{1, 1, 1};
`else
    exp6 = '{1, 2, 3};
`endif
    drv_valid = '0;
    drv_lock  = '0;
    for (int i = 0; i < N; i++) begin
      drv_x[i] = '0; drv_y[i] = '0; drv_ctrl[i] = '0;
    end
    rsp_ready = 1'b1;
    do_reset(3);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_busy", busy, 0);

    // Single op, result and latency
    run_one("t1", 0, 16'd5, 16'd3, 6'b000010, 16'd8, 1'b0, 1'b0);
    chk("t1_latency", last_rise_cyc - last_acc_cyc, 2);

    // Subtract / zero / overflow / and
    run_one("t2_sub", 2, 16'd3, 16'd5, 6'b010011, 16'hFFFE, 1'b0, 1'b1);
    run_one("t2_zero", 2, 16'd3, 16'd3, 6'b010011, 16'h0000, 1'b1, 1'b0);
    run_one("t2_ovf", 2, 16'h7FFF, 16'd1, 6'b000010, 16'h8000, 1'b0, 1'b1);
    run_one("t2_and", 2, 16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, 1'b0, 1'b0);

    // All requesters continuously valid: rotation 0,1,2,3,0,1
    do_reset(2);
    grant_log.delete();
    rsp_id_log.delete();
    for (int i = 0; i < N; i++) issue(i, rand16(), rand16(), 6'($urandom), 1'b0);
    t = 0;
    while ((grant_log.size() < 6) && (t < 80)) begin
      tick();
      t++;
      for (int i = 0; i < N; i++) begin
        if (!drv_valid[i] && (grant_log.size() < 6)) issue(i, rand16(), rand16(), 6'($urandom), 1'b0);
      end
    end
    drv_valid = '0;
    wait_quiet(30);
    chk("t3_grants", grant_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) chk($sformatf("t3_grant%0d", k), grant_log[k], exp3[k]);
      if (k < rsp_id_log.size()) chk($sformatf("t3_rspid%0d", k), rsp_id_log[k], exp3[k]);
    end

    // Consumer stall in RESP
    rsp_ready = 1'b0;
    issue(1, 16'd100, 16'd23, 6'b000010, 1'b0);
    t = 0;
    while (!rsp_valid && (t < 20)) begin
      tick();
      t++;
    end
    chk("t4_reach_resp", rsp_valid, 1);
    issue(3, 16'd1, 16'd1, 6'b000010, 1'b0);
    repeat (5) begin
      tick();
      chk("t4_valid", rsp_valid, 1);
      chk("t4_data", rsp_data, 16'd123);
      chk("t4_id", rsp_id, 1);
      chk("t4_busy", busy, 1);
      chk("t4_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_valid", rsp_valid, 0);
    chk("t4_next_grant", req_ready, 4'b1000);
    wait_quiet(30);

    // Reset during EXEC discards the op
    issue(2, 16'd9, 16'd9, 6'b000010, 1'b0);
    t = 0;
    while (!ready_seen[2] && (t < 20)) begin
      tick();
      t++;
    end
    chk("t5_in_exec", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_zr", rsp_zr, 0);
    chk("t5_rsp_ng", rsp_ng, 0);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    issue(0, 16'd4, 16'd4, 6'b000010, 1'b0);
    issue(3, 16'd6, 16'd6, 6'b000010, 1'b0);
    wait_quiet(40);
    chk("t5_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("t5_first", grant_log[0], 0);
      chk("t5_second", grant_log[1], 3);
    end

    // Lock hint: requester 1 asks to keep the grant
    do_reset(2);
    grant_log.delete();
    issue(1, 16'd2, 16'd2, 6'b000010, 1'b1);
    t = 0;
    while ((grant_log.size() < 1) && (t < 20)) begin
      tick();
      t++;
    end
    for (int i = 0; i < N; i++) begin
      if (!drv_valid[i]) issue(i, rand16(), rand16(), 6'($urandom), (i == 1));
    end
    t = 0;
    while ((grant_log.size() < 3) && (t < 60)) begin
      tick();
      t++;
      for (int i = 0; i < N; i++) begin
        if (!drv_valid[i] && (grant_log.size() < 3)) issue(i, rand16(), rand16(), 6'($urandom), (i == 1));
      end
    end
    drv_valid = '0;
    drv_lock  = '0;
    wait_quiet(30);
    chk("t6_grants", grant_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < grant_log.size()) chk($sformatf("t6_grant%0d", k), grant_log[k], exp6[k]);
    end

    // Randomized traffic with backpressure, dropped requests and sporadic resets
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!drv_valid[i] && ($urandom_range(0, 2) == 0)) begin
          issue(i, rand16(), rand16(), 6'($urandom), 1'($urandom));
        end else if (drv_valid[i] && ($urandom_range(0, 24) == 0)) begin
          drv_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst_n = 1'b1;
      end
    end
    rsp_ready = 1'b1;
    drv_valid = '0;
    wait_quiet(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
